hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4, execution cycles of a mult in the HI/LO unit (range 2..63).
REQ-002 Parameter DIV_CYCLES, default 33, execution cycles of a div in the HI/LO unit (range 2..63).
REQ-003 clk  input  1  single pipeline clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ID_Instruction  input  32  instruction in ID; rs=[25:21], rt=[20:16].
REQ-006 ID_Branch  input  1  conditional branch resolved in ID.
REQ-007 ID_PCSrc  input  2  bit0 = register jump (jr/jalr) resolved in ID.
REQ-008 ID_UsesHiLo  input  1  ID holds mfhi/mflo/mthi/mtlo/mult/div.
REQ-009 EX_MemRead, EX_RegWrite  input  1 each  EX-stage load / register-write flags.
REQ-010 EX_Write_register  input  5  EX-stage destination.
REQ-011 MEM_MemRead  input  1  MEM-stage load flag.
REQ-012 MEM_Write_register  input  5  MEM-stage destination.
REQ-013 EX_MulDiv_start  input  1  one-cycle pulse when mult/div leaves EX.
REQ-014 EX_MulDiv_op  input  1  0 = mult, 1 = div; sampled with start.
REQ-015 Cancel  input  1  exception flush; aborts any HI/LO operation.
REQ-016 PC_Write, IF_ID_Write  output  1 each  0 = hold PC / IF-ID register.
REQ-017 ID_EX_Flush  output  1  1 = insert bubble into ID/EX.
REQ-018 MulDiv_busy  output  1  HI/LO unit is computing.
REQ-019 HiLo_Write  output  1  one-cycle strobe committing the HI/LO result.
REQ-020 Stall_count  output  16  saturating count of stalled cycles.

Function
REQ-021 Load-use hazard = EX_MemRead & EX_Write_register!=0 & (EX_Write_register==rs | EX_Write_register==rt); rt is compared unconditionally.
REQ-022 Branch hazard = (ID_Branch | ID_PCSrc[0]) & ((EX_RegWrite & EX_Write_register!=0 & match rs/rt) | (MEM_MemRead & MEM_Write_register!=0 & match rs/rt)).
REQ-023 HI/LO hazard = ID_UsesHiLo & (state==BUSY).
REQ-024 stall = OR of REQ-021..023; stall drives PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 in the same cycle (combinational, zero latency); otherwise 1, 1, 0.
REQ-025 Cancel forces ID_EX_Flush=1 and PC_Write=IF_ID_Write=1 in that cycle, overriding stall.
REQ-026 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-027 IDLE: on EX_MulDiv_start, load cnt = (op ? DIV_CYCLES : MUL_CYCLES) - 2 and go to BUSY.
REQ-028 BUSY: cnt decrements each cycle; at cnt==0 go to DONE, so DONE is reached N-1 cycles after start.
REQ-029 DONE: HiLo_Write=1 for exactly this cycle; next state IDLE, or BUSY with a fresh cnt load if EX_MulDiv_start is asserted in the DONE cycle.
REQ-030 EX_MulDiv_start during BUSY is ignored; the count is not restarted.
REQ-031 Cancel in any state returns the FSM to IDLE on the next edge; HiLo_Write=0 in a DONE cycle coinciding with Cancel; Cancel has priority over start.
REQ-032 MulDiv_busy = (state==BUSY); HiLo_Write = (state==DONE) & ~Cancel.
REQ-033 Stall_count increments on each edge where stall=1 and Cancel=0, and saturates at 16'hFFFF.

Reset
REQ-034 reset asserted: state=IDLE, cnt=0, Stall_count=0 immediately, regardless of clk.
REQ-035 While reset is high: PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0, MulDiv_busy=0, HiLo_Write=0.
REQ-036 Reset mid-BUSY discards the operation; no HiLo_Write is issued after release.

Structure
REQ-037 Shared package holds the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the rs/rt field bit positions.
REQ-038 One sub-module, hilo_seq, contains the FSM and cnt; hazard detection and Stall_count stay in hazard_ctrl.

Verification
REQ-039 EX_MemRead=1, EX_Write_register=8, ID rs=8 -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle; Stall_count 0->1.
REQ-040 ID_Branch=1, rt=9, EX_RegWrite=1, EX_Write_register=9 -> stall; same with EX_Write_register=0 -> no stall.
REQ-041 start, op=1 (DIV_CYCLES=33) -> MulDiv_busy for 32 cycles, HiLo_Write high exactly one cycle, 32 cycles after start.
REQ-042 mult started (MUL_CYCLES=4), ID_UsesHiLo=1 throughout -> stall for 3 cycles, released in the DONE cycle.
REQ-043 Cancel during BUSY cycle 2 -> IDLE next edge; no HiLo_Write; ID_EX_Flush=1 in the Cancel cycle.
REQ-044 reset asserted mid-BUSY without clk edge -> MulDiv_busy=0 and Stall_count=0 immediately.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, instruction
// field positions and a register-match helper.
package hazard_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   localparam int CNT_W  = 6;
   localparam int STALL_W = 16;

   typedef struct packed {
      logic load_use;
      logic branch;
      logic hilo;
   } hazard_t;

   // $zero is never a real producer, so a zero destination never matches.
   function automatic logic reg_hit(input logic [4:0] dst,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt);
      return (dst != 5'd0) && ((dst == rs) || (dst == rt));
   endfunction

endpackage

// File: rtl/hazard_ctrl_hilo_seq.sv
// HI/LO unit sequencer: tracks a running mult/div and strobes the result
// commit in the single DONE cycle.
module hilo_seq
   import hazard_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 33
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic op_i,
   input  logic cancel_i,
   output logic busy_o,
   output logic hilo_write_o
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] load_val;

   assign load_val = op_i ? DIV_LOAD : MUL_LOAD;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_BUSY;
               cnt_d   = load_val;
            end
         end
         ST_BUSY: begin
            // A new start while busy is dropped; the count keeps running.
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            if (start_i) begin
               state_d = ST_BUSY;
               cnt_d   = load_val;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (cancel_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o       = (state_q == ST_BUSY);
   assign hilo_write_o = (state_q == ST_DONE) && !cancel_i;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, ID-branch and HI/LO interlocks,
// exception flush override and a saturating stall counter.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ID_Instruction,
   input  logic        ID_Branch,
   input  logic [1:0]  ID_PCSrc,
   input  logic        ID_UsesHiLo,
   input  logic        EX_MemRead,
   input  logic        EX_RegWrite,
   input  logic [4:0]  EX_Write_register,
   input  logic        MEM_MemRead,
   input  logic [4:0]  MEM_Write_register,
   input  logic        EX_MulDiv_start,
   input  logic        EX_MulDiv_op,
   input  logic        Cancel,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        ID_EX_Flush,
   output logic        MulDiv_busy,
   output logic        HiLo_Write,
   output logic [15:0] Stall_count
);

   logic [4:0]         id_rs, id_rt;
   hazard_t            haz;
   logic               stall;
   logic               busy;
   logic [STALL_W-1:0] stall_count_q, stall_count_d;

   assign id_rs = ID_Instruction[RS_MSB:RS_LSB];
   assign id_rt = ID_Instruction[RT_MSB:RT_LSB];

   wire unused_bits = &{1'b0, ID_Instruction[31:26], ID_Instruction[15:0], ID_PCSrc[1]};

   hilo_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_hilo_seq (
      .clk          (clk),
      .reset        (reset),
      .start_i      (EX_MulDiv_start),
      .op_i         (EX_MulDiv_op),
      .cancel_i     (Cancel),
      .busy_o       (busy),
      .hilo_write_o (HiLo_Write)
   );

   // rt is compared even for instructions that do not read it; a spurious
   // stall is harmless, a missed one is not.
   always_comb begin
      haz.load_use = EX_MemRead && reg_hit(EX_Write_register, id_rs, id_rt);
      haz.branch   = (ID_Branch || ID_PCSrc[0]) &&
                     ((EX_RegWrite && reg_hit(EX_Write_register, id_rs, id_rt)) ||
                      (MEM_MemRead && reg_hit(MEM_Write_register, id_rs, id_rt)));
      haz.hilo     = ID_UsesHiLo && busy;
   end

   // Reset masks hazards so the pipeline free-runs while held in reset.
   assign stall = !reset && (|haz);

   assign PC_Write    = Cancel || !stall;
   assign IF_ID_Write = Cancel || !stall;
   assign ID_EX_Flush = !reset && (Cancel || stall);
   assign MulDiv_busy = busy;

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && !Cancel && (stall_count_q != {STALL_W{1'b1}})) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign Stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the combinational
// interlocks plus hand-written sequences for the HI/LO sequencer and reset.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ID_Instruction;
   logic        ID_Branch;
   logic [1:0]  ID_PCSrc;
   logic        ID_UsesHiLo;
   logic        EX_MemRead, EX_RegWrite;
   logic [4:0]  EX_Write_register;
   logic        MEM_MemRead;
   logic [4:0]  MEM_Write_register;
   logic        EX_MulDiv_start, EX_MulDiv_op, Cancel;
   logic        PC_Write, IF_ID_Write, ID_EX_Flush, MulDiv_busy, HiLo_Write;
   logic [15:0] Stall_count;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(33)) dut (
      .clk                (clk),
      .reset              (reset),
      .ID_Instruction     (ID_Instruction),
      .ID_Branch          (ID_Branch),
      .ID_PCSrc           (ID_PCSrc),
      .ID_UsesHiLo        (ID_UsesHiLo),
      .EX_MemRead         (EX_MemRead),
      .EX_RegWrite        (EX_RegWrite),
      .EX_Write_register  (EX_Write_register),
      .MEM_MemRead        (MEM_MemRead),
      .MEM_Write_register (MEM_Write_register),
      .EX_MulDiv_start    (EX_MulDiv_start),
      .EX_MulDiv_op       (EX_MulDiv_op),
      .Cancel             (Cancel),
      .PC_Write           (PC_Write),
      .IF_ID_Write        (IF_ID_Write),
      .ID_EX_Flush        (ID_EX_Flush),
      .MulDiv_busy        (MulDiv_busy),
      .HiLo_Write         (HiLo_Write),
      .Stall_count        (Stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [4:0] rs, rt;
      logic       br;
      logic [1:0] pcsrc;
      logic       exmr, exrw;
      logic [4:0] exwr;
      logic       memmr;
      logic [4:0] memwr;
      logic       cancel;
      logic       exp_stall;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(string name, logic [4:0] rs, logic [4:0] rt,
                               logic br, logic [1:0] pcsrc, logic exmr, logic exrw,
                               logic [4:0] exwr, logic memmr, logic [4:0] memwr,
                               logic cancel, logic exp_stall);
      vec_t v;
      v.name = name; v.rs = rs; v.rt = rt; v.br = br; v.pcsrc = pcsrc;
      v.exmr = exmr; v.exrw = exrw; v.exwr = exwr; v.memmr = memmr;
      v.memwr = memwr; v.cancel = cancel; v.exp_stall = exp_stall;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ID_Instruction = 32'd0; ID_Branch = 1'b0; ID_PCSrc = 2'b00;
      ID_UsesHiLo = 1'b0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
      EX_Write_register = 5'd0; MEM_MemRead = 1'b0; MEM_Write_register = 5'd0;
      EX_MulDiv_start = 1'b0; EX_MulDiv_op = 1'b0; Cancel = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_cnt;
      logic [15:0] base;
      int busy_n, hi_n, hi_first, hi_last, stall_n;

      reset = 1'b1;
      clear_inputs();
      EX_MemRead = 1'b1; EX_Write_register = 5'd8; ID_Instruction = {6'd0, 5'd8, 5'd0, 16'd0};
      #3;
      chk("reset_pcw", PC_Write, 1);
      chk("reset_ifw", IF_ID_Write, 1);
      chk("reset_flush", ID_EX_Flush, 0);
      chk("reset_busy", MulDiv_busy, 0);
      chk("reset_hilo", HiLo_Write, 0);
      chk("reset_cnt", Stall_count, 0);
      clear_inputs();
      step();
      reset = 1'b0;
      step();

      vecs[0]  = mk("loaduse_rs",      8, 0, 0, 2'b00, 1, 0, 8, 0, 0, 0, 1);
      vecs[1]  = mk("loaduse_rt",      1, 8, 0, 2'b00, 1, 0, 8, 0, 0, 0, 1);
      vecs[2]  = mk("loaduse_zero",    0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mk("loaduse_nomatch", 3, 4, 0, 2'b00, 1, 0, 8, 0, 0, 0, 0);
      vecs[4]  = mk("branch_ex_rt",    0, 9, 1, 2'b00, 0, 1, 9, 0, 0, 0, 1);
      vecs[5]  = mk("branch_ex_zero",  0, 9, 1, 2'b00, 0, 1, 0, 0, 0, 0, 0);
      vecs[6]  = mk("nobranch_ex",     0, 9, 0, 2'b00, 0, 1, 9, 0, 0, 0, 0);
      vecs[7]  = mk("jr_mem_load",     5, 0, 0, 2'b01, 0, 0, 0, 1, 5, 0, 1);
      vecs[8]  = mk("pcsrc1_only",     5, 0, 0, 2'b10, 0, 0, 0, 1, 5, 0, 0);
      vecs[9]  = mk("branch_mem_noload", 6, 0, 1, 2'b00, 0, 0, 0, 0, 6, 0, 0);
      vecs[10] = mk("cancel_stall",    8, 0, 0, 2'b00, 1, 0, 8, 0, 0, 1, 1);
      vecs[11] = mk("cancel_only",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);

      exp_cnt = 16'd0;
      for (int i = 0; i < 12; i++) begin
         logic e_pcw, e_flush;
         ID_Instruction    = {6'd0, vecs[i].rs, vecs[i].rt, 16'h1234};
         ID_Branch         = vecs[i].br;
         ID_PCSrc          = vecs[i].pcsrc;
         EX_MemRead        = vecs[i].exmr;
         EX_RegWrite       = vecs[i].exrw;
         EX_Write_register = vecs[i].exwr;
         MEM_MemRead       = vecs[i].memmr;
         MEM_Write_register = vecs[i].memwr;
         Cancel            = vecs[i].cancel;
         e_pcw   = vecs[i].cancel | ~vecs[i].exp_stall;
         e_flush = vecs[i].cancel | vecs[i].exp_stall;
         #1;
         chk({vecs[i].name, "_pcw"}, PC_Write, e_pcw);
         chk({vecs[i].name, "_ifw"}, IF_ID_Write, e_pcw);
         chk({vecs[i].name, "_flush"}, ID_EX_Flush, e_flush);
         step();
         if (vecs[i].exp_stall && !vecs[i].cancel) exp_cnt = exp_cnt + 16'd1;
         chk({vecs[i].name, "_cnt"}, Stall_count, exp_cnt);
         clear_inputs();
      end
      step();

      // Divide: 32 busy cycles, commit 32 cycles after start; a restart at
      // sample 5 must be ignored.
      EX_MulDiv_start = 1'b1; EX_MulDiv_op = 1'b1;
      step();
      EX_MulDiv_start = 1'b0;
      busy_n = 0; hi_n = 0; hi_first = -1;
      for (int i = 0; i < 40; i++) begin
         if (MulDiv_busy) busy_n++;
         if (HiLo_Write) begin hi_n++; if (hi_first < 0) hi_first = i; end
         EX_MulDiv_start = (i == 5);
         step();
      end
      EX_MulDiv_start = 1'b0;
      chk("div_busy_cycles", busy_n, 32);
      chk("div_hilo_count", hi_n, 1);
      chk("div_hilo_at", hi_first, 32);

      // Mult with HI/LO consumer waiting, then back-to-back restart in DONE.
      base = Stall_count;
      ID_UsesHiLo = 1'b1;
      EX_MulDiv_start = 1'b1; EX_MulDiv_op = 1'b0;
      step();
      EX_MulDiv_start = 1'b0;
      stall_n = 0; hi_n = 0; hi_first = -1; hi_last = -1;
      for (int i = 0; i < 10; i++) begin
         if (!PC_Write) stall_n++;
         if (HiLo_Write) begin
            hi_n++; hi_last = i;
            if (hi_first < 0) hi_first = i;
         end
         if (i == 3) begin
            chk("mul_done_pcw", PC_Write, 1);
            chk("mul_done_cnt", Stall_count, base + 16'd3);
         end
         EX_MulDiv_start = (i == 3);
         step();
      end
      EX_MulDiv_start = 1'b0;
      chk("mul_stall_cycles", stall_n, 6);
      chk("mul_hilo_count", hi_n, 2);
      chk("mul_hilo_first", hi_first, 3);
      chk("mul_hilo_second", hi_last, 7);
      chk("mul_end_cnt", Stall_count, base + 16'd6);
      ID_UsesHiLo = 1'b0;

      // Cancel in the second BUSY cycle.
      EX_MulDiv_start = 1'b1; EX_MulDiv_op = 1'b1;
      step();
      EX_MulDiv_start = 1'b0;
      step();
      chk("cancel_pre_busy", MulDiv_busy, 1);
      Cancel = 1'b1;
      #1;
      chk("cancel_flush", ID_EX_Flush, 1);
      chk("cancel_pcw", PC_Write, 1);
      step();
      Cancel = 1'b0;
      chk("cancel_idle", MulDiv_busy, 0);
      hi_n = 0; busy_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (HiLo_Write) hi_n++;
         if (MulDiv_busy) busy_n++;
         step();
      end
      chk("cancel_no_hilo", hi_n, 0);
      chk("cancel_no_busy", busy_n, 0);

      // Cancel coinciding with DONE suppresses the commit strobe.
      EX_MulDiv_start = 1'b1; EX_MulDiv_op = 1'b0;
      step();
      EX_MulDiv_start = 1'b0;
      step(); step(); step();
      Cancel = 1'b1;
      #1;
      chk("cancel_done_hilo", HiLo_Write, 0);
      step();
      Cancel = 1'b0;
      chk("cancel_done_after", HiLo_Write, 0);

      // Asynchronous reset in the middle of a divide.
      ID_UsesHiLo = 1'b1;
      EX_MulDiv_start = 1'b1; EX_MulDiv_op = 1'b1;
      base = Stall_count;
      step();
      EX_MulDiv_start = 1'b0;
      step(); step();
      chk("pre_reset_cnt", Stall_count, base + 16'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_busy", MulDiv_busy, 0);
      chk("async_reset_cnt", Stall_count, 0);
      chk("async_reset_pcw", PC_Write, 1);
      chk("async_reset_flush", ID_EX_Flush, 0);
      reset = 1'b0;
      ID_UsesHiLo = 1'b0;
      hi_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (HiLo_Write) hi_n++;
         step();
      end
      chk("reset_no_hilo", hi_n, 0);
      chk("reset_no_busy", MulDiv_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
